// File: rtl/tristate_conduit_mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tcm_ctrl_pkg
// Purpose  : Shared types and helpers for the tristate conduit memory
//            controller: FSM state encoding and phase-counter sizing.
// Revision : 1.0 - initial release
// ============================================================================
package tcm_ctrl_pkg;

  // Bus-cycle phases of one external memory access
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    SETUP  = 3'd2,
    STROBE = 3'd3,
    HOLD   = 3'd4,
    TURN   = 3'd5
  } state_t;

  // Bits needed to hold values 0..max_val; at least one bit
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/tristate_conduit_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tristate_conduit_mem_ctrl
// Purpose  : Avalon-MM slave to tristate-conduit master for a shared 16-bit
//            asynchronous memory. Requests the shared pins, then sequences
//            chip-select, strobes and bus direction through programmable
//            setup / strobe / hold / turnaround phases.
// Revision : 1.0 - initial release
// ============================================================================
module tristate_conduit_mem_ctrl
  import tcm_ctrl_pkg::*;
#(
  parameter int ADDR_W    = 22,
  parameter int DATA_W    = 16,
  parameter int SETUP_CYC = 1,
  parameter int WAIT_CYC  = 3,
  parameter int HOLD_CYC  = 1,
  parameter int TURN_CYC  = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [DATA_W-1:0] avs_writedata,
  output logic              avs_waitrequest,
  output logic [DATA_W-1:0] avs_readdata,
  output logic              avs_readdatavalid,
  output logic              tcm_request,
  input  logic              tcm_grant,
  output logic [ADDR_W-1:0] tcm_address_out,
  output logic              tcm_read_n_out,
  output logic              tcm_write_n_out,
  output logic              tcm_chipselect_n_out,
  output logic [DATA_W-1:0] tcm_data_out,
  output logic              tcm_data_outen,
  input  logic [DATA_W-1:0] tcm_data_in
);

  localparam int MAX_SW    = (SETUP_CYC > WAIT_CYC) ? SETUP_CYC : WAIT_CYC;
  localparam int MAX_HT    = (HOLD_CYC > TURN_CYC) ? HOLD_CYC : TURN_CYC;
  localparam int MAX_PHASE = (MAX_SW > MAX_HT) ? MAX_SW : MAX_HT;
  localparam int CNT_W     = cnt_w(MAX_PHASE);

  typedef logic [CNT_W-1:0] cnt_t;

  state_t              r_state;
  state_t              w_next;
  cnt_t                r_cnt;
  cnt_t                w_cnt_next;
  logic                w_done;
  logic                w_accept;
  logic                w_active;
  logic                w_strobe;
  logic                r_is_write;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;

  // Remaining cycles of the current phase reach zero on its last cycle
  assign w_done          = (r_cnt == '0);
  assign w_accept        = (r_state == IDLE) && (avs_read || avs_write);
  assign avs_waitrequest = (r_state != IDLE);

  // Outputs are registered from the next state so pins line up with the phase
  assign w_active = (w_next == SETUP) || (w_next == STROBE) || (w_next == HOLD);
  assign w_strobe = (w_next == STROBE);

  // Phase sequencing; zero-length phases are skipped at the transition
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = REQ;
      REQ:     if (tcm_grant) w_next = (SETUP_CYC > 0) ? SETUP : STROBE;
      SETUP:   if (w_done) w_next = STROBE;
      STROBE:  if (w_done) w_next = (HOLD_CYC > 0) ? HOLD :
                                    (TURN_CYC > 0) ? TURN : IDLE;
      HOLD:    if (w_done) w_next = (TURN_CYC > 0) ? TURN : IDLE;
      TURN:    if (w_done) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Phase down-counter: reload on every phase entry, saturate at zero
  always_comb begin
    w_cnt_next = r_cnt;
    if (w_next != r_state) begin
      case (w_next)
        SETUP:   w_cnt_next = cnt_t'(SETUP_CYC - 1);
        STROBE:  w_cnt_next = cnt_t'(WAIT_CYC - 1);
        HOLD:    w_cnt_next = cnt_t'(HOLD_CYC - 1);
        TURN:    w_cnt_next = cnt_t'(TURN_CYC - 1);
        default: w_cnt_next = '0;
      endcase
    end else if (r_cnt != '0) begin
      w_cnt_next = r_cnt - 1'b1;
    end
  end

  // State and phase-counter registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Command capture, registered conduit outputs and read-data return
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_is_write           <= 1'b0;
      r_addr               <= '0;
      r_wdata              <= '0;
      tcm_request          <= 1'b0;
      tcm_chipselect_n_out <= 1'b1;
      tcm_read_n_out       <= 1'b1;
      tcm_write_n_out      <= 1'b1;
      tcm_data_outen       <= 1'b0;
      tcm_address_out      <= '0;
      tcm_data_out         <= '0;
      avs_readdata         <= '0;
      avs_readdatavalid    <= 1'b0;
    end else begin
      // A simultaneous read and write is served as a write
      if (w_accept) begin
        r_is_write <= avs_write;
        r_addr     <= avs_address;
        r_wdata    <= avs_writedata;
      end
      tcm_request          <= (w_next == REQ) || w_active;
      tcm_chipselect_n_out <= !w_active;
      tcm_read_n_out       <= !(w_strobe && !r_is_write);
      tcm_write_n_out      <= !(w_strobe && r_is_write);
      tcm_data_outen       <= w_active && r_is_write;
      if (w_active) begin
        tcm_address_out <= r_addr;
        if (r_is_write) tcm_data_out <= r_wdata;
      end
      // Sample the pad on the edge that ends the final strobe cycle
      if ((r_state == STROBE) && w_done && !r_is_write) begin
        avs_readdata      <= tcm_data_in;
        avs_readdatavalid <= 1'b1;
      end else begin
        avs_readdatavalid <= 1'b0;
      end
    end
  end

  // Never drive the pad while the memory is driving it
  a_no_contention: assert property (@(posedge clk) disable iff (!reset_n)
    !(tcm_data_outen && !tcm_read_n_out));

endmodule
`default_nettype wire

// File: tb/tb_tristate_conduit_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_tristate_conduit_mem_ctrl
// Purpose  : Self-checking bench: per-cycle vector table for single read and
//            write, plus directed sequences for grant stall, read+write
//            collision, back-to-back reads, mid-access reset and a
//            zero-length-phase configuration.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tristate_conduit_mem_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic        reset_n = 1'b0;
  logic [21:0] avs_address = '0;
  logic        avs_read = 1'b0, avs_write = 1'b0;
  logic [15:0] avs_writedata = '0;
  logic        waitreq, rdv, req, rd_n, wr_n, cs_n, oe;
  logic [15:0] readdata, dout, din;
  logic [21:0] addr_out;
  logic        grant = 1'b1;
  logic [15:0] mem_val = 16'hBEEF;
  assign din = rd_n ? 16'h0000 : mem_val;

  tristate_conduit_mem_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_waitrequest(waitreq),
    .avs_readdata(readdata), .avs_readdatavalid(rdv),
    .tcm_request(req), .tcm_grant(grant), .tcm_address_out(addr_out),
    .tcm_read_n_out(rd_n), .tcm_write_n_out(wr_n),
    .tcm_chipselect_n_out(cs_n), .tcm_data_out(dout),
    .tcm_data_outen(oe), .tcm_data_in(din)
  );

  // Zero-length setup/hold/turnaround instance
  logic [21:0] z_address = '0;
  logic        z_read = 1'b0, z_write = 1'b0;
  logic [15:0] z_writedata = '0;
  logic        z_waitreq, z_rdv, z_req, z_rd_n, z_wr_n, z_cs_n, z_oe;
  logic [15:0] z_readdata, z_dout, z_din;
  logic [21:0] z_addr_out;
  logic        z_grant = 1'b1;
  assign z_din = z_rd_n ? 16'h0000 : 16'hC3C3;

  tristate_conduit_mem_ctrl #(
    .SETUP_CYC(0), .WAIT_CYC(1), .HOLD_CYC(0), .TURN_CYC(0)
  ) dut_z (
    .clk(clk), .reset_n(reset_n),
    .avs_address(z_address), .avs_read(z_read), .avs_write(z_write),
    .avs_writedata(z_writedata), .avs_waitrequest(z_waitreq),
    .avs_readdata(z_readdata), .avs_readdatavalid(z_rdv),
    .tcm_request(z_req), .tcm_grant(z_grant), .tcm_address_out(z_addr_out),
    .tcm_read_n_out(z_rd_n), .tcm_write_n_out(z_wr_n),
    .tcm_chipselect_n_out(z_cs_n), .tcm_data_out(z_dout),
    .tcm_data_outen(z_oe), .tcm_data_in(z_din)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {waitrequest, request, cs_n, read_n, write_n, outen, readdatavalid, addr, data_out, readdata}
  function automatic logic [63:0] all_outs();
    return 64'({waitreq, req, cs_n, rd_n, wr_n, oe, rdv, addr_out, dout, readdata});
  endfunction

  // Start a command in the current cycle (cycle 0); reports waitrequest seen
  task automatic issue(input logic rd, input logic wr, input logic [21:0] a,
                       input logic [15:0] d, output logic busy);
    tick();
    busy          = waitreq;
    avs_read      = rd;
    avs_write     = wr;
    avs_address   = a;
    avs_writedata = d;
  endtask

  // Run n cycles, clearing the command and tallying conduit activity
  task automatic observe(input int n, output int cs_lo, output int rd_lo,
                         output int wr_lo, output int oe_hi, output int rdv_n,
                         output int turn_n, output logic [15:0] rdata);
    cs_lo = 0; rd_lo = 0; wr_lo = 0; oe_hi = 0; rdv_n = 0; turn_n = 0; rdata = '0;
    for (int i = 0; i < n; i++) begin
      tick();
      avs_read  = 1'b0;
      avs_write = 1'b0;
      if (!cs_n) cs_lo++;
      if (!rd_n) rd_lo++;
      if (!wr_n) wr_lo++;
      if (oe) oe_hi++;
      if (rdv) begin rdv_n++; rdata = readdata; end
      if (waitreq && !req) turn_n++;
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (waitreq && n < 20) begin tick(); n++; end
    chk(name, 64'(waitreq), 64'(0));
  endtask

  typedef struct {
    logic       is_wr;
    int         cyc;
    logic [6:0] exp;   // {waitreq, req, cs_n, rd_n, wr_n, oe, rdv}
  } vec_t;

  vec_t vecs[18];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int   cs_lo, rd_lo, wr_lo, oe_hi, rdv_n, turn_n;
    logic [15:0] rdata;
    logic busy;

    // Single read of 0x12345 then single write of 0x3FFFFF/0xA55A
    vecs[0]  = '{1'b0, 0, 7'b0011100};
    vecs[1]  = '{1'b0, 1, 7'b1111100};
    vecs[2]  = '{1'b0, 2, 7'b1101100};
    vecs[3]  = '{1'b0, 3, 7'b1100100};
    vecs[4]  = '{1'b0, 4, 7'b1100100};
    vecs[5]  = '{1'b0, 5, 7'b1100100};
    vecs[6]  = '{1'b0, 6, 7'b1101101};
    vecs[7]  = '{1'b0, 7, 7'b1011100};
    vecs[8]  = '{1'b0, 8, 7'b0011100};
    vecs[9]  = '{1'b1, 0, 7'b0011100};
    vecs[10] = '{1'b1, 1, 7'b1111100};
    vecs[11] = '{1'b1, 2, 7'b1101110};
    vecs[12] = '{1'b1, 3, 7'b1101010};
    vecs[13] = '{1'b1, 4, 7'b1101010};
    vecs[14] = '{1'b1, 5, 7'b1101010};
    vecs[15] = '{1'b1, 6, 7'b1101110};
    vecs[16] = '{1'b1, 7, 7'b1011100};
    vecs[17] = '{1'b1, 8, 7'b0011100};

    // Reset values
    tick(); tick();
    chk("reset_outs", all_outs(), 64'({7'b0011100, 22'h0, 16'h0, 16'h0}));
    chk("reset_z", 64'({z_waitreq, z_req, z_cs_n, z_rd_n, z_wr_n, z_oe, z_rdv}),
        64'(7'b0011100));
    reset_n = 1'b1;
    tick();

    // Table-driven per-cycle read and write
    for (int i = 0; i < 18; i++) begin
      tick();
      if (vecs[i].cyc == 0) begin
        avs_read      = !vecs[i].is_wr;
        avs_write     = vecs[i].is_wr;
        avs_address   = vecs[i].is_wr ? 22'h3FFFFF : 22'h12345;
        avs_writedata = 16'hA55A;
      end else begin
        avs_read  = 1'b0;
        avs_write = 1'b0;
      end
      chk($sformatf("vec%0d_pins", i),
          64'({waitreq, req, cs_n, rd_n, wr_n, oe, rdv}), 64'(vecs[i].exp));
      if (!vecs[i].exp[4])
        chk($sformatf("vec%0d_addr", i), 64'(addr_out),
            64'(vecs[i].is_wr ? 22'h3FFFFF : 22'h12345));
      if (vecs[i].exp[1])
        chk($sformatf("vec%0d_dout", i), 64'(dout), 64'(16'hA55A));
      if (vecs[i].exp[0])
        chk($sformatf("vec%0d_rdata", i), 64'(readdata), 64'(16'hBEEF));
    end

    // Grant withheld: request stays up, no chip select or strobe until grant
    grant   = 1'b0;
    mem_val = 16'h1357;
    issue(1'b1, 1'b0, 22'h00777, 16'h0, busy);
    for (int k = 1; k <= 5; k++) begin
      tick();
      avs_read = 1'b0;
      chk($sformatf("grant_wait_c%0d", k), 64'({req, cs_n, rd_n}), 64'(3'b111));
    end
    grant = 1'b1;
    tick();
    chk("grant_setup", 64'({req, cs_n, rd_n}), 64'(3'b101));
    grant = 1'b0;   // drop after setup must not abort the access
    tick();
    chk("grant_strobe", 64'({req, cs_n, rd_n}), 64'(3'b100));
    observe(6, cs_lo, rd_lo, wr_lo, oe_hi, rdv_n, turn_n, rdata);
    chk("grant_rdv", 64'(rdv_n), 64'(1));
    chk("grant_rdata", 64'(rdata), 64'(16'h1357));
    grant = 1'b1;
    wait_idle("grant_idle");

    // Read and write together: only the write happens
    issue(1'b1, 1'b1, 22'h0ABCD, 16'h5AA5, busy);
    observe(9, cs_lo, rd_lo, wr_lo, oe_hi, rdv_n, turn_n, rdata);
    chk("both_wr_lo", 64'(wr_lo), 64'(3));
    chk("both_rd_lo", 64'(rd_lo), 64'(0));
    chk("both_oe", 64'(oe_hi), 64'(5));
    chk("both_rdv", 64'(rdv_n), 64'(0));

    // Back-to-back reads with one turnaround cycle between them
    mem_val = 16'h2468;
    issue(1'b1, 1'b0, 22'h00100, 16'h0, busy);
    observe(7, cs_lo, rd_lo, wr_lo, oe_hi, rdv_n, turn_n, rdata);
    chk("b2b_a_cs", 64'(cs_lo), 64'(5));
    chk("b2b_a_turn", 64'(turn_n), 64'(1));
    chk("b2b_a_rdata", 64'({rdv_n[3:0], rdata}), 64'({4'd1, 16'h2468}));
    issue(1'b1, 1'b0, 22'h00101, 16'h0, busy);
    chk("b2b_accept_c8", 64'(busy), 64'(0));
    mem_val = 16'h8642;
    observe(8, cs_lo, rd_lo, wr_lo, oe_hi, rdv_n, turn_n, rdata);
    chk("b2b_b_rd", 64'(rd_lo), 64'(3));
    chk("b2b_b_rdata", 64'({rdv_n[3:0], rdata}), 64'({4'd1, 16'h8642}));

    // Reset during the strobe of a read
    mem_val = 16'hFFFF;
    issue(1'b1, 1'b0, 22'h00200, 16'h0, busy);
    observe(3, cs_lo, rd_lo, wr_lo, oe_hi, rdv_n, turn_n, rdata);
    tick();
    chk("rst_mid_strobe", 64'(rd_n), 64'(0));
    reset_n = 1'b0;
    tick();
    chk("rst_mid_outs", all_outs(), 64'({7'b0011100, 22'h0, 16'h0, 16'h0}));
    reset_n = 1'b1;
    observe(6, cs_lo, rd_lo, wr_lo, oe_hi, rdv_n, turn_n, rdata);
    chk("rst_mid_no_rdv", 64'(rdv_n + cs_lo), 64'(0));
    mem_val = 16'h0F0F;
    issue(1'b1, 1'b0, 22'h00300, 16'h0, busy);
    chk("rst_after_accept", 64'(busy), 64'(0));
    observe(8, cs_lo, rd_lo, wr_lo, oe_hi, rdv_n, turn_n, rdata);
    chk("rst_after_rdata", 64'({rdv_n[3:0], rdata}), 64'({4'd1, 16'h0F0F}));

    // Zero-length phases: strobe at cycle 2, data at 3, next accept at 3
    tick();
    z_read = 1'b1; z_address = 22'h00001;
    chk("z_c0_wait", 64'(z_waitreq), 64'(0));
    tick();
    z_read = 1'b0;
    chk("z_c1", 64'({z_waitreq, z_req, z_cs_n, z_rd_n}), 64'(4'b1111));
    tick();
    chk("z_c2", 64'({z_waitreq, z_req, z_cs_n, z_rd_n, z_rdv}), 64'(5'b11000));
    chk("z_c2_addr", 64'(z_addr_out), 64'(22'h00001));
    tick();
    chk("z_c3", 64'({z_waitreq, z_req, z_cs_n, z_rd_n, z_rdv}), 64'(5'b00111));
    chk("z_c3_rdata", 64'(z_readdata), 64'(16'hC3C3));
    z_write = 1'b1; z_address = 22'h00002; z_writedata = 16'h6006;
    tick();
    z_write = 1'b0;
    chk("z_w_c1", 64'({z_waitreq, z_req}), 64'(2'b11));
    tick();
    chk("z_w_c2", 64'({z_cs_n, z_wr_n, z_oe, z_rd_n}), 64'(4'b0011));
    chk("z_w_dout", 64'(z_dout), 64'(16'h6006));
    tick();
    chk("z_w_c3", 64'({z_waitreq, z_cs_n, z_wr_n, z_oe}), 64'(4'b0110));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tristate_conduit_mem_ctrl.md
Name: tristate_conduit_mem_ctrl

Overview:
- Avalon-MM slave to tristate-conduit master (TCM) controller for a shared 16-bit asynchronous external memory (22-bit word address).
- Accepts single read/write commands and requests the shared pins from the conduit pin-sharer via tcm_request/tcm_grant.
- Sequences chip-select, strobes and data-bus direction with programmable setup/strobe/hold/turnaround phases.
- Outputs feed the tristate conduit bridge translator; the split data out/outen/in is merged onto the inout pad there.

Parameters:
- ADDR_W, 22, address width
- DATA_W, 16, data width
- SETUP_CYC, 1, cycles cs_n low with address valid before strobe (0 allowed)
- WAIT_CYC, 3, strobe-low cycles (minimum 1)
- HOLD_CYC, 1, cycles after strobe release with cs_n/address/write data held (0 allowed)
- TURN_CYC, 1, bus-idle cycles after release before next request (0 allowed)

Ports:
- clk  in  1  single clock
- reset_n  in  1  synchronous active-low reset
- avs_address  in  ADDR_W  word address
- avs_read  in  1  read command
- avs_write  in  1  write command
- avs_writedata  in  DATA_W  write data
- avs_waitrequest  out  1  command not accepted
- avs_readdata  out  DATA_W  read data
- avs_readdatavalid  out  1  read data strobe
- tcm_request  out  1  pin-share request
- tcm_grant  in  1  pin-share grant
- tcm_address_out  out  ADDR_W  memory address
- tcm_read_n_out  out  1  active-low output enable
- tcm_write_n_out  out  1  active-low write enable
- tcm_chipselect_n_out  out  1  active-low chip select
- tcm_data_out  out  DATA_W  write data to pad
- tcm_data_outen  out  1  pad drive enable
- tcm_data_in  in  DATA_W  read data from pad

Behaviour:
- Clock and reset: one clock clk; reset is synchronous, active-low (reset_n sampled on clk rising edge).
- Reset values: state IDLE, tcm_request 0, read_n/write_n/chipselect_n 1, outen 0, address 0, data_out 0, readdata 0, readdatavalid 0. All TCM outputs are registered.
- avs_waitrequest = (state != IDLE), combinational. Command is accepted in IDLE when read or write is high; address, data and direction are captured. Both high: write served, read dropped.
- FSM: IDLE -> REQ -> SETUP -> STROBE -> HOLD -> TURN -> IDLE. Phases with 0 cycles are skipped.
- REQ: tcm_request 1. Stay in REQ until tcm_grant is sampled 1. tcm_request stays 1 through HOLD and drops on TURN entry.
- SETUP: cs_n 0, address driven. For writes, outen 1 and data_out driven.
- STROBE: read_n 0 (read) or write_n 0 (write) for WAIT_CYC cycles. Read data is captured from tcm_data_in at the clock edge ending the last STROBE cycle.
- HOLD: strobes 1; cs_n, address and write data are held. avs_readdatavalid is 1 for exactly one cycle on the first cycle after the last STROBE cycle; this applies even when HOLD_CYC=0.
- TURN: cs_n 1, outen 0, request 0.
- Read latency with defaults and immediate grant: accept at cycle 0, REQ 1, SETUP 2, STROBE 3-5, readdatavalid at 6, TURN 7, next accept at 8.
- Phase counter width is clog2(max phase param + 1). The counter reloads on each phase entry and never wraps.
- tcm_grant drop after SETUP: ignored; the transaction completes.
- Reset asserted mid-operation: on the next edge all outputs take reset values. No readdatavalid is issued and the transaction is lost.
- outen is never 1 while read_n is 0 (checked by assertion).

Decomposition:
- Package tcm_ctrl_pkg: state enum (IDLE, REQ, SETUP, STROBE, HOLD, TURN) and a cnt_w() width function.
- No sub-module; a single FSM with one phase down-counter.

Test Plan:
- Read 0x12345, grant tied 1, memory model returns 0xBEEF -> cs_n low cycles 2-6, read_n low cycles 3-5, readdatavalid=1 at cycle 6 with readdata=0xBEEF.
- Write 0x3FFFFF/0xA55A -> outen=1 and data_out=0xA55A cycles 2-6, write_n low cycles 3-5, waitrequest=0 again at cycle 8.
- Grant held 0 for 5 cycles -> tcm_request stays 1 in REQ; SETUP starts the cycle after grant is sampled 1; no strobe before grant.
- Read and write both high -> only the write is performed, no readdatavalid; then back-to-back reads -> TURN gap of 1 cycle with cs_n=1 between them.
- reset_n low during STROBE of a read -> all outputs at reset values the next cycle, no readdatavalid, next command accepted normally.
- SETUP_CYC=0, HOLD_CYC=0, TURN_CYC=0, WAIT_CYC=1 -> read strobe 1 cycle at cycle 2, readdatavalid at 3, next accept at 3.
